// File: rtl/game_pkg.sv
// Shared widths and the round FSM encoding for the tank score keeper.
package game_pkg;

    localparam int unsigned LIVES_W = 3;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned INVUL_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_OVER
    } score_st_t;

endpackage

// File: rtl/tank_hit_unit.sv
// Per-tank hit edge detector, invulnerability frame counter and lives counter.
module tank_hit_unit
    import game_pkg::*;
#(
    parameter int unsigned LIVES        = 3,
    parameter int unsigned INVUL_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               play_ok,
    input  logic               freeze,
    input  logic               sof,
    input  logic               hit,
    output logic               hit_accepted_c,
    output logic [LIVES_W-1:0] lives,
    output logic               invul,
    output logic               lives_zero_c
);

    logic               hit_prev_q, hit_prev_d;
    logic [INVUL_W-1:0] invul_cnt_q, invul_cnt_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic               invul_q, invul_d;

    always_comb begin
        hit_prev_d     = hit;
        invul_cnt_d    = invul_cnt_q;
        lives_d        = lives_q;
        hit_accepted_c = hit && !hit_prev_q && play_ok && (invul_cnt_q == '0);

        // A fresh hit reloads the window; the frame decrement is dropped that cycle.
        if (hit_accepted_c) begin
            invul_cnt_d = INVUL_W'(INVUL_FRAMES);
            if (lives_q != '0) begin
                lives_d = lives_q - LIVES_W'(1);
            end
        end else if (sof && !freeze && (invul_cnt_q != '0)) begin
            invul_cnt_d = invul_cnt_q - INVUL_W'(1);
        end

        if (clear) begin
            hit_prev_d  = 1'b0;
            invul_cnt_d = '0;
            lives_d     = LIVES_W'(LIVES);
        end

        invul_d      = (invul_cnt_d != '0);
        lives_zero_c = (lives_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_prev_q  <= 1'b0;
            invul_cnt_q <= '0;
            lives_q     <= LIVES_W'(LIVES);
            invul_q     <= 1'b0;
        end else begin
            hit_prev_q  <= hit_prev_d;
            invul_cnt_q <= invul_cnt_d;
            lives_q     <= lives_d;
            invul_q     <= invul_d;
        end
    end

    assign lives = lives_q;
    assign invul = invul_q;

endmodule

// File: rtl/tank_score_keeper.sv
// Round bookkeeping for two tanks: lives, cross-wired scores, sticky win/lose flags.
module tank_score_keeper
    import game_pkg::*;
#(
    parameter int unsigned LIVES        = 3,
    parameter int unsigned WIN_SCORE    = 5,
    parameter int unsigned INVUL_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               runEn,
    input  logic               clearScores,
    input  logic               tank1Hit,
    input  logic               tank2Hit,
    output logic [SCORE_W-1:0] tank1Score,
    output logic [SCORE_W-1:0] tank2Score,
    output logic [LIVES_W-1:0] tank1Lives,
    output logic [LIVES_W-1:0] tank2Lives,
    output logic               tank1Invul,
    output logic               tank2Invul,
    output logic               tank1Win,
    output logic               tank2Win,
    output logic               tank1Lose,
    output logic               tank2Lose
);

    score_st_t          state_q, state_d;
    logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
    logic               win1_q, win1_d, win2_q, win2_d;
    logic               lose1_q, lose1_d, lose2_q, lose2_d;
    logic               acc1_c, acc2_c, zero1_c, zero2_c;
    logic               play_ok, freeze;

    // runEn gates hits directly so a hit during a map-change drop is never counted.
    assign play_ok = (state_q == S_PLAY) && runEn;
    assign freeze  = (state_q == S_OVER);

    tank_hit_unit #(.LIVES(LIVES), .INVUL_FRAMES(INVUL_FRAMES)) u_hit1 (
        .clk(clk), .reset(reset), .clear(clearScores), .play_ok(play_ok),
        .freeze(freeze), .sof(startOfFrame), .hit(tank1Hit),
        .hit_accepted_c(acc1_c), .lives(tank1Lives), .invul(tank1Invul),
        .lives_zero_c(zero1_c)
    );

    tank_hit_unit #(.LIVES(LIVES), .INVUL_FRAMES(INVUL_FRAMES)) u_hit2 (
        .clk(clk), .reset(reset), .clear(clearScores), .play_ok(play_ok),
        .freeze(freeze), .sof(startOfFrame), .hit(tank2Hit),
        .hit_accepted_c(acc2_c), .lives(tank2Lives), .invul(tank2Invul),
        .lives_zero_c(zero2_c)
    );

    always_comb begin
        state_d  = state_q;
        score1_d = score1_q;
        score2_d = score2_q;

        // A hit on one tank is a point for the other.
        if (acc2_c && (score1_q != SCORE_W'(WIN_SCORE))) begin
            score1_d = score1_q + SCORE_W'(1);
        end
        if (acc1_c && (score2_q != SCORE_W'(WIN_SCORE))) begin
            score2_d = score2_q + SCORE_W'(1);
        end

        win1_d  = win1_q  || (score1_d == SCORE_W'(WIN_SCORE));
        win2_d  = win2_q  || (score2_d == SCORE_W'(WIN_SCORE));
        lose1_d = lose1_q || zero1_c;
        lose2_d = lose2_q || zero2_c;

        case (state_q)
            S_IDLE: if (runEn) state_d = S_PLAY;
            S_PLAY: begin
                if (win1_d || win2_d || lose1_d || lose2_d) begin
                    state_d = S_OVER;
                end else if (!runEn) begin
                    state_d = S_IDLE;
                end
            end
            S_OVER:  state_d = S_OVER;
            default: state_d = S_IDLE;
        endcase

        if (clearScores) begin
            state_d  = S_IDLE;
            score1_d = '0;
            score2_d = '0;
            win1_d   = 1'b0;
            win2_d   = 1'b0;
            lose1_d  = 1'b0;
            lose2_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            score1_q <= '0;
            score2_q <= '0;
            win1_q   <= 1'b0;
            win2_q   <= 1'b0;
            lose1_q  <= 1'b0;
            lose2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            win1_q   <= win1_d;
            win2_q   <= win2_d;
            lose1_q  <= lose1_d;
            lose2_q  <= lose2_d;
        end
    end

    assign tank1Score = score1_q;
    assign tank2Score = score2_q;
    assign tank1Win   = win1_q;
    assign tank2Win   = win2_q;
    assign tank1Lose  = lose1_q;
    assign tank2Lose  = lose2_q;

endmodule

// File: tb/tb_tank_score_keeper.sv
// Bench: default-parameter instance plus a short-round instance, both against a game-rule model.
module tb_tank_score_keeper;

    logic clk = 1'b0;
    logic reset, startOfFrame, runEn, clearScores, tank1Hit, tank2Hit;

    logic [3:0] o_s1 [2];
    logic [3:0] o_s2 [2];
    logic [2:0] o_l1 [2];
    logic [2:0] o_l2 [2];
    logic       o_i1 [2];
    logic       o_i2 [2];
    logic       o_w1 [2];
    logic       o_w2 [2];
    logic       o_d1 [2];
    logic       o_d2 [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit rand_sof = 1'b0;

    // Per-instance game parameters: [0] defaults, [1] short round where a win is reachable.
    int P_LIVES [2] = '{3, 7};
    int P_WIN   [2] = '{5, 2};
    int P_INV   [2] = '{60, 1};

    int m_lives [2][2];
    int m_score [2][2];
    int m_inv   [2][2];
    bit m_prev  [2][2];
    bit m_win   [2][2];
    bit m_lose  [2][2];
    bit m_play  [2];
    bit m_over  [2];

    always #5 clk = ~clk;

    tank_score_keeper u_dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .runEn(runEn),
        .clearScores(clearScores), .tank1Hit(tank1Hit), .tank2Hit(tank2Hit),
        .tank1Score(o_s1[0]), .tank2Score(o_s2[0]), .tank1Lives(o_l1[0]), .tank2Lives(o_l2[0]),
        .tank1Invul(o_i1[0]), .tank2Invul(o_i2[0]), .tank1Win(o_w1[0]), .tank2Win(o_w2[0]),
        .tank1Lose(o_d1[0]), .tank2Lose(o_d2[0])
    );

    tank_score_keeper #(.LIVES(7), .WIN_SCORE(2), .INVUL_FRAMES(1)) u_dut_short (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .runEn(runEn),
        .clearScores(clearScores), .tank1Hit(tank1Hit), .tank2Hit(tank2Hit),
        .tank1Score(o_s1[1]), .tank2Score(o_s2[1]), .tank1Lives(o_l1[1]), .tank2Lives(o_l2[1]),
        .tank1Invul(o_i1[1]), .tank2Invul(o_i2[1]), .tank1Win(o_w1[1]), .tank2Win(o_w2[1]),
        .tank1Lose(o_d1[1]), .tank2Lose(o_d2[1])
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int t = 0; t < 2; t++) begin
                m_lives[k][t] = P_LIVES[k];
                m_score[k][t] = 0;
                m_inv[k][t]   = 0;
                m_prev[k][t]  = 1'b0;
                m_win[k][t]   = 1'b0;
                m_lose[k][t]  = 1'b0;
            end
            m_play[k] = 1'b0;
            m_over[k] = 1'b0;
        end
    endtask

    // One clock of game rules, evaluated from the inputs present at the edge.
    task automatic model_step();
        bit hits [2];
        bit acc  [2];
        hits[0] = tank1Hit;
        hits[1] = tank2Hit;
        if (reset || clearScores) begin
            model_clear();
        end else begin
            for (int k = 0; k < 2; k++) begin
                for (int t = 0; t < 2; t++) begin
                    acc[t] = hits[t] && !m_prev[k][t] && m_play[k] && runEn && (m_inv[k][t] == 0);
                    m_prev[k][t] = hits[t];
                end
                for (int t = 0; t < 2; t++) begin
                    if (acc[t]) begin
                        if (m_lives[k][t] > 0) m_lives[k][t]--;
                        if (m_score[k][1-t] < P_WIN[k]) m_score[k][1-t]++;
                        m_inv[k][t] = P_INV[k];
                    end else if (startOfFrame && !m_over[k] && m_inv[k][t] > 0) begin
                        m_inv[k][t]--;
                    end
                end
                for (int t = 0; t < 2; t++) begin
                    if (m_lives[k][t] == 0) m_lose[k][t] = 1'b1;
                    if (m_score[k][t] == P_WIN[k]) m_win[k][t] = 1'b1;
                end
                if (m_play[k]) begin
                    if (m_win[k][0] || m_win[k][1] || m_lose[k][0] || m_lose[k][1]) begin
                        m_play[k] = 1'b0;
                        m_over[k] = 1'b1;
                    end else if (!runEn) begin
                        m_play[k] = 1'b0;
                    end
                end else if (!m_over[k] && runEn) begin
                    m_play[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d_t1score", k), int'(o_s1[k]), m_score[k][0]);
            chk($sformatf("u%0d_t2score", k), int'(o_s2[k]), m_score[k][1]);
            chk($sformatf("u%0d_t1lives", k), int'(o_l1[k]), m_lives[k][0]);
            chk($sformatf("u%0d_t2lives", k), int'(o_l2[k]), m_lives[k][1]);
            chk($sformatf("u%0d_t1invul", k), int'(o_i1[k]), int'(m_inv[k][0] != 0));
            chk($sformatf("u%0d_t2invul", k), int'(o_i2[k]), int'(m_inv[k][1] != 0));
            chk($sformatf("u%0d_t1win",   k), int'(o_w1[k]), int'(m_win[k][0]));
            chk($sformatf("u%0d_t2win",   k), int'(o_w2[k]), int'(m_win[k][1]));
            chk($sformatf("u%0d_t1lose",  k), int'(o_d1[k]), int'(m_lose[k][0]));
            chk($sformatf("u%0d_t2lose",  k), int'(o_d2[k]), int'(m_lose[k][1]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        cyc++;
        startOfFrame = rand_sof ? ($urandom_range(0, 3) == 0) : ((cyc % 4) == 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_clear();
        clearScores = 1'b1;
        tick();
        clearScores = 1'b0;
    endtask

    initial begin
        reset = 1'b1; startOfFrame = 1'b0; runEn = 1'b0;
        clearScores = 1'b0; tank1Hit = 1'b0; tank2Hit = 1'b0;
        model_clear();
        #12;
        check_all();
        chk("rst_t1lives", int'(o_l1[0]), 3);
        chk("rst_t2score", int'(o_s2[0]), 0);
        reset = 1'b0;

        // Single hit pulse: lives, opponent score and the invulnerability window.
        runEn = 1'b1;
        ticks(3);
        tank1Hit = 1'b1;
        tick();
        chk("hit1_lives", int'(o_l1[0]), 2);
        chk("hit1_score2", int'(o_s2[0]), 1);
        chk("hit1_invul", int'(o_i1[0]), 1);
        tank1Hit = 1'b0;
        ticks(200);
        chk("invul_held", int'(o_i1[0]), 1);
        ticks(50);
        chk("invul_expired", int'(o_i1[0]), 0);

        // Long level-high hit counts once.
        tank1Hit = 1'b1;
        ticks(200);
        chk("held_lives", int'(o_l1[0]), 1);
        chk("held_score2", int'(o_s2[0]), 2);
        chk("short_win2", int'(o_w2[1]), 1);
        chk("short_lives1", int'(o_l1[1]), 5);
        tank1Hit = 1'b0;
        ticks(250);

        // Third edge ends the round; later hits are ignored.
        chk("pre_lose1", int'(o_d1[0]), 0);
        tank1Hit = 1'b1;
        tick();
        chk("lose1", int'(o_d1[0]), 1);
        chk("lose1_lives", int'(o_l1[0]), 0);
        tank1Hit = 1'b0;
        tick();
        tank2Hit = 1'b1;
        tick();
        tank2Hit = 1'b0;
        ticks(5);
        chk("over_score1", int'(o_s1[0]), 0);
        chk("over_lives2", int'(o_l2[0]), 3);

        // Simultaneous edges down to a draw.
        pulse_clear();
        chk("clr_lose1", int'(o_d1[0]), 0);
        chk("clr_lives1", int'(o_l1[0]), 3);
        ticks(3);
        for (int r = 0; r < 3; r++) begin
            tank1Hit = 1'b1; tank2Hit = 1'b1;
            tick();
            tank1Hit = 1'b0; tank2Hit = 1'b0;
            if (r == 1) begin
                chk("draw_prelives1", int'(o_l1[0]), 1);
                chk("draw_prelives2", int'(o_l2[0]), 1);
            end
            if (r < 2) ticks(250);
        end
        chk("draw_lose1", int'(o_d1[0]), 1);
        chk("draw_lose2", int'(o_d2[0]), 1);
        chk("draw_score1", int'(o_s1[0]), 3);
        chk("draw_score2", int'(o_s2[0]), 3);
        ticks(2);

        // runEn drop with a hit edge inside it.
        pulse_clear();
        ticks(3);
        tank1Hit = 1'b1;
        tick();
        tank1Hit = 1'b0;
        ticks(250);
        runEn = 1'b0;
        tick();
        tank2Hit = 1'b1;
        tick();
        runEn = 1'b1;
        tank2Hit = 1'b0;
        ticks(4);
        chk("drop_lives2", int'(o_l2[0]), 3);
        chk("drop_score1", int'(o_s1[0]), 0);
        chk("drop_lives1", int'(o_l1[0]), 2);
        chk("drop_score2", int'(o_s2[0]), 1);

        // clearScores beats a coincident hit; async reset drops invul at once.
        ticks(250);
        tank1Hit = 1'b1; clearScores = 1'b1;
        tick();
        chk("clrhit_lives1", int'(o_l1[0]), 3);
        chk("clrhit_score2", int'(o_s2[0]), 0);
        tank1Hit = 1'b0; clearScores = 1'b0;
        ticks(2);
        tank1Hit = 1'b1;
        tick();
        tank1Hit = 1'b0;
        chk("pre_rst_invul", int'(o_i1[0]), 1);
        ticks(5);
        reset = 1'b1;
        model_clear();
        #1;
        chk("rst_invul", int'(o_i1[0]), 0);
        check_all();
        #2;
        reset = 1'b0;

        // Randomized play against the rule model.
        rand_sof = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) < 3) tank1Hit = ~tank1Hit;
            if ($urandom_range(0, 9) < 3) tank2Hit = ~tank2Hit;
            runEn       = ($urandom_range(0, 19) != 0);
            clearScores = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
